gf12_sram64_be_stream_ctrl: RTL and testbench
=============================================

Name: gf12_sram64_be_stream_ctrl

Overview:
- Client-side controller that drives the 1-write/1-read port interface of the 64-bit byte-enable SRAM wrappers (CE0/A0/D0/WE0/WEM0 write port; CE1/A1 request and Q1 data read port, 1-cycle read latency).
- Presents valid/ready write, read-request and read-response channels to accelerator logic.
- Buffers read data for backpressure and prevents same-bank write/read collisions.
- Optionally zero-fills the memory after reset or on request.

Parameters:
- ABITS, 19, word address width.
- BANK_LSB, 13, LSB of the physical bank-select field; the bank is addr[ABITS-1:BANK_LSB].
- INIT_ON_RESET, 1, if 1, zero-fill all 2^ABITS words after reset.

Ports:
- CLK  in  1  clock
- RSTN  in  1  asynchronous active-low reset
- INIT_REQ  in  1  pulse: start a zero-fill (honoured in RUN only)
- INIT_BUSY  out  1  high in DRAIN or INIT
- WR_VALID  in  1  write request valid
- WR_READY  out  1  write request accepted
- WR_ADDR  in  ABITS  write word address
- WR_DATA  in  64  write data
- WR_STRB  in  8  byte strobes; bit i covers data[8i+7:8i]
- RD_VALID  in  1  read request valid
- RD_READY  out  1  read request accepted
- RD_ADDR  in  ABITS  read word address
- RSP_VALID  out  1  read data valid
- RSP_READY  in  1  read data consumed
- RSP_DATA  out  64  read data
- CE0, WE0  out  1  SRAM write-port enable and write
- A0  out  ABITS  SRAM write address
- D0  out  64  SRAM write data
- WEM0  out  64  SRAM bit write mask
- CE1  out  1  SRAM read enable
- A1  out  ABITS  SRAM read address
- Q1  in  64  SRAM read data, valid the cycle after CE1

Behaviour:
- Single clock CLK. Reset RSTN is asynchronous and active-low.
- Reset values:
  - FSM state = INIT if INIT_ON_RESET else RUN.
  - Init counter, inflight flag and 2-entry response FIFO are cleared.
  - WR_READY, RD_READY, RSP_VALID, CE0, WE0, CE1 = 0; A0, D0, WEM0, A1, RSP_DATA = 0.
  - INIT_BUSY = INIT_ON_RESET.
- FSM states:
  - RUN -> DRAIN on INIT_REQ.
  - DRAIN -> INIT when inflight==0 (the FIFO may still hold data and keeps draining).
  - INIT -> RUN after writing address 2^ABITS-1.
  - INIT_REQ is ignored outside RUN.
- INIT behaviour:
  - Each cycle drives CE0=WE0=1, A0=counter, D0=0, WEM0=all ones, then increments the counter.
  - The counter resets to 0 on the INIT->RUN transition.
- WR_READY = (state==RUN). It is combinational and independent of WR_VALID.
- Write handshake:
  - On WR_VALID&&WR_READY, the same cycle drives CE0=WE0=1, A0=WR_ADDR, D0=WR_DATA, WEM0[8i+7:8i]={8{WR_STRB[i]}}.
  - If WR_STRB==0, the request is consumed but CE0=WE0=0.
  - Outside these cases CE0=WE0=0.
- Bank conflict (write priority): when WR_VALID and WR_READY are high and bank(WR_ADDR)==bank(RD_ADDR), RD_READY=0 that cycle.
- RD_READY = (state==RUN) && no bank conflict && (fifo_count + inflight - pop) < 2, where pop = RSP_VALID&&RSP_READY. The combinational path RSP_READY->RD_READY is intended.
- Read handshake:
  - On RD_VALID&&RD_READY, the same cycle drives CE1=1, A1=RD_ADDR, and sets inflight for the next cycle.
  - Otherwise CE1=0 and A1=0.
- Read data path:
  - While inflight is high, Q1 is pushed into the FIFO at the clock edge.
  - RSP_VALID/RSP_DATA come from the FIFO head, giving a latency of 2 cycles from acceptance to RSP_VALID.
  - Push and pop in the same cycle is legal, with the count unchanged.
  - Sustained 1 read/cycle when RSP_READY is held high.
  - RSP_DATA holds while RSP_VALID && !RSP_READY.
- Response ordering equals acceptance order.
- Address handling: no wrap or check beyond ABITS; addresses are passed straight through.
- Reset mid-operation: in-flight reads and FIFO contents are discarded, and no RSP_VALID appears after reset release.
- A reset during INIT restarts the zero-fill from address 0 if INIT_ON_RESET=1.

Test Plan:
- Reset with INIT_ON_RESET=1, ABITS=4: INIT_BUSY=1 for exactly 16 cycles, 16 writes A0=0..15 with D0=0 and WEM0=all ones, then WR_READY=RD_READY=1.
- Write addr 5, data 0x1122334455667788, WR_STRB=0x0F, then read addr 5 -> same-cycle WEM0=0x00000000FFFFFFFF; RSP_VALID 2 cycles after read accept; RSP_DATA=0x0000000055667788 after init.
- Back-to-back reads at addrs 0..7 with RSP_READY=1 -> RD_READY never drops, 8 responses on consecutive cycles, in order.
- RSP_READY=0 while issuing reads -> exactly 2 accepted, then RD_READY=0 and RSP_DATA stable. Raise RSP_READY -> RD_READY=1 the same cycle.
- Concurrent WR_ADDR=0x00010 and RD_ADDR=0x00020 (BANK_LSB=13, same bank) -> write accepted, RD_READY=0. RD_ADDR=0x02000 -> both accepted, CE0=CE1=1.
- INIT_REQ with one read in flight -> DRAIN for 1 cycle, then INIT. The pending response still delivered. Assert RSTN=0 mid-INIT -> all outputs 0 immediately, no stray RSP_VALID.

Source files
------------

// File: rtl/gf12_sram64_be_stream_ctrl_if.sv
// gf12_sram64_be_stream_ctrl_if: client channels and SRAM port bundle for the stream controller
interface gf12_sram64_be_stream_ctrl_if #(parameter int ABITS = 19);
  logic             INIT_REQ, INIT_BUSY;
  logic             WR_VALID, WR_READY;
  logic [ABITS-1:0] WR_ADDR;
  logic [63:0]      WR_DATA;
  logic [7:0]       WR_STRB;
  logic             RD_VALID, RD_READY;
  logic [ABITS-1:0] RD_ADDR;
  logic             RSP_VALID, RSP_READY;
  logic [63:0]      RSP_DATA;
  logic             CE0, WE0, CE1;
  logic [ABITS-1:0] A0, A1;
  logic [63:0]      D0, WEM0, Q1;
  modport slave (
    input  INIT_REQ, WR_VALID, WR_ADDR, WR_DATA, WR_STRB, RD_VALID, RD_ADDR, RSP_READY, Q1,
    output INIT_BUSY, WR_READY, RD_READY, RSP_VALID, RSP_DATA, CE0, WE0, A0, D0, WEM0, CE1, A1
  );
  modport master (
    output INIT_REQ, WR_VALID, WR_ADDR, WR_DATA, WR_STRB, RD_VALID, RD_ADDR, RSP_READY, Q1,
    input  INIT_BUSY, WR_READY, RD_READY, RSP_VALID, RSP_DATA, CE0, WE0, A0, D0, WEM0, CE1, A1
  );
endinterface

// File: rtl/gf12_sram64_be_stream_ctrl.sv
// gf12_sram64_be_stream_ctrl: valid/ready front end for a 1W/1R byte-enable SRAM with zero-fill
module gf12_sram64_be_stream_ctrl #(
  parameter int ABITS         = 19,
  parameter int BANK_LSB      = 13,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic CLK,
  input logic RSTN,
  gf12_sram64_be_stream_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, INIT} state_t;
  state_t           state, state_nxt;
  logic [ABITS-1:0] cnt;
  logic             inflight, wp, rp;
  logic [1:0]       count;
  logic [63:0]      fifo [2];
  logic             run, init, wr_fire, rd_ok, rd_fire, rsp_valid, pop, conflict, wr_en;
  logic [63:0]      wem;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= INIT_ON_RESET ? INIT : RUN;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == RUN && bus.INIT_REQ) ? DRAIN :
                (state == DRAIN && !inflight) ? INIT :
                (state == INIT && &cnt) ? RUN : state;
  // Strobes and enables are masked by RSTN so the SRAM sees nothing while reset is held
  always_comb begin
    run       = RSTN && state == RUN;
    init      = RSTN && state == INIT;
    rsp_valid = count != 2'd0;
    pop       = rsp_valid && bus.RSP_READY;
    wr_fire   = bus.WR_VALID && run;
    wr_en     = wr_fire && |bus.WR_STRB;
    conflict  = wr_fire && bus.WR_ADDR[ABITS-1:BANK_LSB] == bus.RD_ADDR[ABITS-1:BANK_LSB];
    rd_ok     = run && !conflict && ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    rd_fire   = bus.RD_VALID && rd_ok;
    for (int i = 0; i < 8; i++) wem[8*i +: 8] = {8{bus.WR_STRB[i]}};
    bus.WR_READY  = run;
    bus.RD_READY  = rd_ok;
    bus.INIT_BUSY = state != RUN;
    bus.CE0       = init || wr_en;
    bus.WE0       = init || wr_en;
    bus.A0        = init ? cnt : wr_fire ? bus.WR_ADDR : '0;
    bus.D0        = wr_fire ? bus.WR_DATA : '0;
    bus.WEM0      = init ? '1 : wr_fire ? wem : '0;
    bus.CE1       = rd_fire;
    bus.A1        = rd_fire ? bus.RD_ADDR : '0;
    bus.RSP_VALID = rsp_valid;
    bus.RSP_DATA  = fifo[rp];
  end
  // Q1 lands one cycle after CE1, so inflight marks the edge at which it is captured
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      cnt      <= '0;
      inflight <= 1'b0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      count    <= 2'd0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
    end else begin
      cnt      <= init ? cnt + 1'b1 : '0;
      inflight <= rd_fire;
      if (inflight) begin
        fifo[wp] <= bus.Q1;
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
endmodule

// File: tb/tb_gf12_sram64_be_stream_ctrl.sv
// tb_gf12_sram64_be_stream_ctrl: scoreboarded random traffic, comb vector table and directed corner sequences
module tb_gf12_sram64_be_stream_ctrl;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  gf12_sram64_be_stream_ctrl_if #(.ABITS(4))  ia ();
  gf12_sram64_be_stream_ctrl_if #(.ABITS(19)) ib ();
  gf12_sram64_be_stream_ctrl #(.ABITS(4), .BANK_LSB(2), .INIT_ON_RESET(1'b1))
    dut_a (.CLK(clk), .RSTN(rstn), .bus(ia.slave));
  gf12_sram64_be_stream_ctrl #(.ABITS(19), .BANK_LSB(13), .INIT_ON_RESET(1'b0))
    dut_b (.CLK(clk), .RSTN(rstn), .bus(ib.slave));
  logic [63:0] sram [16];
  always @(posedge clk) begin
    if (ia.CE0 && ia.WE0) sram[ia.A0] <= (sram[ia.A0] & ~ia.WEM0) | (ia.D0 & ia.WEM0);
    if (ia.CE1) ia.Q1 <= sram[ia.A1];
  end
  assign ib.Q1 = '0;
  typedef struct {
    logic wv; logic [18:0] wa; logic [7:0] ws; logic rv; logic [18:0] ra;
    logic wrdy, rrdy, ce0, ce1; logic [18:0] a1; logic [63:0] wem;
  } vec_t;
  vec_t        tv [6];
  logic [63:0] exp_mem [16];
  logic [63:0] q [$];
  logic [63:0] held;
  int          checks = 0, failures = 0, acc;
  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  // Reference model: memory image plus ordered queue of expected responses
  task automatic step();
    if (ia.RSP_VALID) chk("rsp_pending", q.size() != 0, 1);
    if (ia.RSP_VALID && ia.RSP_READY && q.size() != 0) chk("rsp_data", ia.RSP_DATA, q.pop_front());
    if (ia.WR_VALID && ia.WR_READY && ia.WR_ADDR[3:2] == ia.RD_ADDR[3:2]) chk("bank_conflict", ia.RD_READY, 0);
    if (ia.RD_VALID && ia.RD_READY) q.push_back(exp_mem[ia.RD_ADDR]);
    if (ia.WR_VALID && ia.WR_READY)
      for (int i = 0; i < 8; i++) if (ia.WR_STRB[i]) exp_mem[ia.WR_ADDR][8*i +: 8] = ia.WR_DATA[8*i +: 8];
  endtask
  task automatic idle();
    ia.INIT_REQ = 0; ia.WR_VALID = 0; ia.WR_ADDR = '0; ia.WR_DATA = '0; ia.WR_STRB = '0;
    ia.RD_VALID = 0; ia.RD_ADDR = '0; ia.RSP_READY = 0;
    ib.INIT_REQ = 0; ib.WR_VALID = 0; ib.WR_ADDR = '0; ib.WR_DATA = '0; ib.WR_STRB = '0;
    ib.RD_VALID = 0; ib.RD_ADDR = '0; ib.RSP_READY = 1;
  endtask
  task automatic wait_init(input string nm);
    int n = 0;
    while (ia.INIT_BUSY && n < 40) begin
      chk(nm, {ia.CE0, ia.WE0, ia.A0, ia.D0, ia.WEM0}, {2'b11, 4'(n), 64'h0, {64{1'b1}}});
      n++;
      cyc(); #1; step();
    end
    chk({nm, "_len"}, n, 16);
  endtask
  initial begin
    tv[0] = '{1'b1, 19'h00010, 8'hFF, 1'b1, 19'h00020, 1'b1, 1'b0, 1'b1, 1'b0, 19'h0, {64{1'b1}}};
    tv[1] = '{1'b1, 19'h00010, 8'hFF, 1'b1, 19'h02000, 1'b1, 1'b1, 1'b1, 1'b1, 19'h02000, {64{1'b1}}};
    tv[2] = '{1'b0, 19'h00010, 8'hFF, 1'b1, 19'h00020, 1'b1, 1'b1, 1'b0, 1'b1, 19'h00020, 64'h0};
    tv[3] = '{1'b1, 19'h7E000, 8'h00, 1'b1, 19'h7FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0, 64'h0};
    tv[4] = '{1'b1, 19'h12345, 8'hA5, 1'b0, 19'h12345, 1'b1, 1'b0, 1'b1, 1'b0, 19'h0, 64'hFF00FF0000FF00FF};
    tv[5] = '{1'b1, 19'h7FFFF, 8'h01, 1'b1, 19'h00000, 1'b1, 1'b1, 1'b1, 1'b1, 19'h0, 64'h00000000000000FF};
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    idle();
    #12;
    chk("rst_outs_a", {ia.WR_READY, ia.RD_READY, ia.RSP_VALID, ia.CE0, ia.WE0, ia.CE1, ia.A0, ia.A1, ia.RSP_DATA, ia.INIT_BUSY},
        {6'b0, 4'h0, 4'h0, 64'h0, 1'b1});
    chk("rst_outs_b", {ib.WR_READY, ib.RD_READY, ib.CE0, ib.CE1, ib.INIT_BUSY}, 5'b0);
    cyc(); rstn = 1; #1; step();
    wait_init("init_fill");
    chk("run_ready", {ia.WR_READY, ia.RD_READY}, 2'b11);
    // Partial-strobe write then readback
    cyc(); ia.WR_VALID = 1; ia.WR_ADDR = 4'd5; ia.WR_DATA = 64'h1122334455667788; ia.WR_STRB = 8'h0F;
    #1; chk("wem_strb", {ia.CE0, ia.WE0, ia.WEM0}, {2'b11, 64'h00000000FFFFFFFF}); step();
    cyc(); ia.WR_VALID = 0; ia.RD_VALID = 1; ia.RD_ADDR = 4'd5; ia.RSP_READY = 1;
    #1; chk("rd_issue", {ia.RD_READY, ia.CE1, ia.A1}, {2'b11, 4'd5}); step();
    cyc(); ia.RD_VALID = 0; #1; chk("rsp_lat1", ia.RSP_VALID, 0); step();
    cyc(); #1; chk("rsp_lat2", {ia.RSP_VALID, ia.RSP_DATA}, {1'b1, 64'h0000000055667788}); step();
    // Back-to-back streaming reads
    for (int c = 0; c < 12; c++) begin
      cyc(); ia.RD_VALID = c < 8; ia.RD_ADDR = 4'(c); #1;
      if (c < 8) chk("b2b_ready", ia.RD_READY, 1);
      if (c >= 2 && c < 10) chk("b2b_rsp_valid", ia.RSP_VALID, 1);
      step();
    end
    chk("b2b_drained", q.size(), 0);
    // Backpressure: two reads fit, then stall with held data
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(); ia.RD_VALID = 1; ia.RD_ADDR = 4'(4 + c); ia.RSP_READY = 0; #1;
      acc += int'(ia.RD_VALID && ia.RD_READY);
      if (c >= 2) chk("bp_stall", ia.RD_READY, 0);
      if (c == 2) begin held = ia.RSP_DATA; chk("bp_head", ia.RSP_DATA, q[0]); end
      if (c > 2) chk("bp_hold", ia.RSP_DATA, held);
      step();
    end
    chk("bp_accepts", acc, 2);
    cyc(); ia.RSP_READY = 1; ia.RD_ADDR = 4'd1; #1; chk("bp_release", ia.RD_READY, 1); step();
    for (int c = 0; c < 4; c++) begin cyc(); ia.RD_VALID = 0; #1; step(); end
    chk("bp_drained", q.size(), 0);
    // Combinational bank-conflict vectors on the full-width instance
    for (int k = 0; k < 6; k++) begin
      cyc();
      ib.WR_VALID = tv[k].wv; ib.WR_ADDR = tv[k].wa; ib.WR_STRB = tv[k].ws; ib.WR_DATA = 64'hA5A5;
      ib.RD_VALID = tv[k].rv; ib.RD_ADDR = tv[k].ra;
      #1;
      chk($sformatf("tbl%0d", k), {ib.WR_READY, ib.RD_READY, ib.CE0, ib.CE1, ib.A1, ib.WEM0},
          {tv[k].wrdy, tv[k].rrdy, tv[k].ce0, tv[k].ce1, tv[k].a1, tv[k].wem});
      #1; ib.WR_VALID = 0; ib.RD_VALID = 0;
    end
    // Random mixed traffic against the model
    for (int c = 0; c < 400; c++) begin
      cyc();
      ia.WR_VALID = 1'($urandom_range(0, 1)); ia.WR_ADDR = 4'($urandom); ia.WR_DATA = {$urandom(), $urandom()};
      ia.WR_STRB = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ia.RD_VALID = 1'($urandom_range(0, 1)); ia.RD_ADDR = 4'($urandom);
      ia.RSP_READY = $urandom_range(0, 3) != 0;
      #1; step();
    end
    for (int c = 0; c < 6; c++) begin cyc(); ia.WR_VALID = 0; ia.RD_VALID = 0; ia.RSP_READY = 1; #1; step(); end
    chk("rand_drained", q.size(), 0);
    // Zero-fill request with a read outstanding
    cyc(); ia.RD_VALID = 1; ia.RD_ADDR = 4'd5; ia.RSP_READY = 0; #1; chk("ireq_rd", ia.RD_READY, 1); step();
    cyc(); ia.RD_VALID = 0; ia.INIT_REQ = 1; #1; step();
    cyc(); ia.INIT_REQ = 0; #1;
    chk("drain", {ia.INIT_BUSY, ia.WR_READY, ia.RD_READY, ia.CE0}, 4'b1000); step();
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    cyc(); #1; chk("drain_to_init", {ia.CE0, ia.A0, ia.RSP_VALID}, {1'b1, 4'd0, 1'b1}); step();
    cyc(); ia.RSP_READY = 1; #1; step();
    cyc(); #1; step();
    chk("ireq_rsp_done", q.size(), 0);
    #2; rstn = 0; #1;
    chk("rst_mid", {ia.WR_READY, ia.RD_READY, ia.RSP_VALID, ia.CE0, ia.WE0, ia.CE1, ia.A0, ia.A1, ia.WEM0, ia.D0}, '0);
    cyc(); rstn = 1; #1; step();
    wait_init("reinit");
    for (int c = 0; c < 4; c++) begin cyc(); #1; step(); end
    chk("final_idle", {ia.RSP_VALID, ia.WR_READY, ia.RD_READY}, 3'b011);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
